clock_divider_multi: RTL and testbench
======================================

Name: clock_divider_multi

Overview:
Parametrised successor to the single fixed-ratio clock stretcher. It generates NUM_CH independent divided clock outputs from one system clock. Each channel has runtime-programmable high and low phase lengths, so ratio and duty cycle are programmable. Ratio changes are glitch-free: they take effect only at a period boundary. The block sits between the configuration register bank and any logic needing slow strobes or clocks, e.g. sensor sampling or LED/PWM timing.

Parameters:
NUM_CH, 4, number of divider channels (1..16)
CNT_W, 8, width of phase-length counters and config fields
CH_W, 2, width of channel-select field; must satisfy 2^CH_W >= NUM_CH
DEF_HIGH, 9, reset value of every channel's high-phase length
DEF_LOW, 9, reset value of every channel's low-phase length

Ports:
clock  input  1  system clock; all logic on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  NUM_CH  per-channel run enable, level-sensitive
cfg_we  input  1  config write strobe, one cycle per write
cfg_ch  input  CH_W  channel targeted by cfg_we
cfg_high  input  CNT_W  new high-phase length in clock cycles
cfg_low  input  CNT_W  new low-phase length in clock cycles
clk_out  output  NUM_CH  divided outputs, registered
rise  output  NUM_CH  one-cycle strobe coinciding with first high cycle of clk_out[i]
busy  output  NUM_CH  1 while channel state is not OFF
pend  output  NUM_CH  1 while shadow config is written but not yet applied

Behaviour:
- Reset (async, reset=0), every channel:
  - state=OFF, clk_out=0, rise=0, busy=0, pend=0, counter=0
  - active and shadow high=DEF_HIGH, active and shadow low=DEF_LOW
- Effective length = field value, except 0 is treated as 1. Period = eff_high+eff_low cycles.
- Per-channel FSM, states OFF / HIGH / LOW, one-hot encoded:
  - OFF, en[i]=1 sampled: apply shadow if pend (clear pend); ->HIGH; cnt<=eff_high-1; clk_out<=1; rise<=1. Latency is one cycle from en sampled to first high cycle.
  - HIGH: if cnt==0 then ->LOW, cnt<=eff_low-1, clk_out<=0; else cnt<=cnt-1.
  - LOW, cnt!=0: cnt<=cnt-1.
  - LOW, cnt==0, en[i]=1: apply shadow if pend; ->HIGH with reload, clk_out<=1, rise<=1.
  - LOW, cnt==0, en[i]=0: ->OFF, clk_out stays 0.
- rise is 0 in every cycle not listed above.
- Disabling mid-period: the current period always completes; no truncated high pulse is allowed.
- Config write: cfg_we=1 writes shadow high/low of cfg_ch and sets pend[cfg_ch]. Writes with cfg_ch>=NUM_CH are ignored.
- A write landing in the same cycle as an apply:
  - apply uses the pre-write shadow value
  - shadow takes the new value
  - pend stays 1
- Back-to-back writes before an apply: last write wins.
- Active values never change outside an apply event, so duty and period are constant within any period.
- Counter arithmetic is CNT_W-bit unsigned; no wrap occurs because reload is always len-1 with len>=1.
- Reset asserted mid-period: outputs go to reset values immediately (async); pending config is lost.

Optional Feature:
Macro CLKDIV_SYNC_EN.
- Defined: adds input port sync (1 bit). When sync=1 is sampled, every channel with en[i]=1 restarts: apply shadow if pend, ->HIGH, cnt<=eff_high-1, clk_out<=1, rise<=1. This overrides the normal HIGH/LOW transition that cycle, phase-aligning all enabled channels.
- Defined, channels with en[i]=0: not affected by sync.
  - OFF stays OFF.
  - A channel finishing its period continues to OFF.
- Not defined: the sync port is absent and there is no realignment logic.

Test Plan:
- Reset release, en=4'b0001, defaults 9/9 -> clk_out[0] high 9 cycles, low 9, period 18; rise[0] pulses every 18 cycles; other channels stay 0.
- Write ch1 high=3 low=1 while ch1 is running at 9/9 -> pend[1]=1; current period finishes 9/9; next period is 3/1 and pend[1] clears at that rise.
- cfg_high=0, cfg_low=0 on ch2, en[2]=1 -> clk_out[2] toggles every cycle (1/1); rise[2] fires every 2 cycles.
- Drop en[0] during the 3rd high cycle -> remaining 6 high + 9 low cycles complete, then busy[0]=0, clk_out[0]=0, no rise.
- Write to ch3 in the same cycle ch3 reloads -> old shadow applied, pend[3] remains 1, new value applied next period; write with cfg_ch=5 when NUM_CH=4 -> no change.
- With CLKDIV_SYNC_EN: ch0 at 5/5 and ch1 at 2/7 free-running, pulse sync -> both rise the next cycle together; ch2 with en=0 stays low.

Source files
------------

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NUM_CH independent divided clocks with programmable high/low phases.
// Optional macro CLKDIV_SYNC_EN adds a 'sync' input that phase-aligns all enabled channels.
`default_nettype none

module clock_divider_multi #(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 8,
   parameter int CH_W     = 2,
   parameter int DEF_HIGH = 9,
   parameter int DEF_LOW  = 9
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_CH-1:0] en,
`ifdef CLKDIV_SYNC_EN
   input  logic              sync,
`endif
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_high,
   input  logic [CNT_W-1:0]  cfg_low,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] rise,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] pend
);

   typedef enum logic [2:0] {
      S_OFF  = 3'b001,
      S_HIGH = 3'b010,
      S_LOW  = 3'b100
   } state_t;

   // Counter reload for a phase: a zero-length field behaves as one cycle.
   function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] len);
      return (len == '0) ? '0 : len - 1'b1;
   endfunction

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_t           state_q;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] act_high_q, act_low_q;
      logic [CNT_W-1:0] sh_high_q, sh_low_q;
      logic             clk_q, rise_q, pend_q;
      logic             w_wr, w_sync_hit, w_start;
      logic [CNT_W-1:0] w_new_high;

      assign w_wr = cfg_we && (cfg_ch == CH_W'(i));
`ifdef CLKDIV_SYNC_EN
      assign w_sync_hit = sync;
`else
      assign w_sync_hit = 1'b0;
`endif
      // A new period starts only from OFF or at the very end of LOW, unless sync forces it.
      assign w_start = en[i] && ((state_q == S_OFF) ||
                                 ((state_q == S_LOW) && (cnt_q == '0)) ||
                                 w_sync_hit);
      assign w_new_high = pend_q ? sh_high_q : act_high_q;

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            state_q    <= S_OFF;
            cnt_q      <= '0;
            act_high_q <= CNT_W'(DEF_HIGH);
            act_low_q  <= CNT_W'(DEF_LOW);
            sh_high_q  <= CNT_W'(DEF_HIGH);
            sh_low_q   <= CNT_W'(DEF_LOW);
            clk_q      <= 1'b0;
            rise_q     <= 1'b0;
            pend_q     <= 1'b0;
         end else begin
            rise_q <= 1'b0;
            if (w_start) begin
               if (pend_q) begin
                  act_high_q <= sh_high_q;
                  act_low_q  <= sh_low_q;
               end
               state_q <= S_HIGH;
               cnt_q   <= reload(w_new_high);
               clk_q   <= 1'b1;
               rise_q  <= 1'b1;
            end else begin
               case (state_q)
                  S_HIGH: begin
                     if (cnt_q == '0) begin
                        state_q <= S_LOW;
                        cnt_q   <= reload(act_low_q);
                        clk_q   <= 1'b0;
                     end else begin
                        cnt_q <= cnt_q - 1'b1;
                     end
                  end
                  S_LOW: begin
                     if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                     end else begin
                        state_q <= S_OFF;
                        clk_q   <= 1'b0;
                     end
                  end
                  default: begin
                     state_q <= S_OFF;
                     clk_q   <= 1'b0;
                  end
               endcase
            end
            // The apply above reads the pre-write shadow; a coincident write re-arms pend.
            if (w_wr) begin
               sh_high_q <= cfg_high;
               sh_low_q  <= cfg_low;
               pend_q    <= 1'b1;
            end else if (w_start) begin
               pend_q <= 1'b0;
            end
         end
      end

      assign clk_out[i] = clk_q;
      assign rise[i]    = rise_q;
      assign busy[i]    = (state_q != S_OFF);
      assign pend[i]    = pend_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: period-position reference model feeding a scoreboard queue, plus
// table-driven phases and hand-written corner sequences.
`default_nettype none

module tb_clock_divider_multi;
   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;
   localparam int CH_W   = 3;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic [NUM_CH-1:0] en = '0;
   logic             cfg_we = 1'b0;
   logic [CH_W-1:0]  cfg_ch = '0;
   logic [CNT_W-1:0] cfg_high = '0;
   logic [CNT_W-1:0] cfg_low = '0;
`ifdef CLKDIV_SYNC_EN
   logic             sync = 1'b0;
`endif
   wire [NUM_CH-1:0] clk_out, rise, busy, pend;

   clock_divider_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W),
                         .DEF_HIGH(9), .DEF_LOW(9)) dut (
      .clock(clock), .reset(reset), .en(en),
`ifdef CLKDIV_SYNC_EN
      .sync(sync),
`endif
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_high(cfg_high), .cfg_low(cfg_low),
      .clk_out(clk_out), .rise(rise), .busy(busy), .pend(pend)
   );

   always #5 clock = ~clock;

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   typedef struct packed {
      logic [NUM_CH-1:0] c, r, b, p;
   } obs_t;

   typedef struct {
      logic [NUM_CH-1:0] en;
      logic              we;
      logic [CH_W-1:0]   ch;
      logic [CNT_W-1:0]  hi, lo;
      int                n;
      logic [NUM_CH-1:0] exp_busy, exp_pend;
   } phase_t;

   obs_t q[$];
   int total = 0;
   int bad = 0;

   bit m_run[NUM_CH];
   bit m_pend[NUM_CH];
   int m_pos[NUM_CH], m_h[NUM_CH], m_l[NUM_CH], m_sh[NUM_CH], m_sl[NUM_CH];

   function automatic int eff(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_run[c] = 0; m_pend[c] = 0; m_pos[c] = 0;
         m_h[c] = 9; m_l[c] = 9; m_sh[c] = 9; m_sl[c] = 9;
      end
      q.delete();
   endtask

   // Model tracks position within the period rather than a phase counter.
   task automatic model_step();
      obs_t e;
      bit sync_now;
      bit start;
      sync_now = 0;
`ifdef CLKDIV_SYNC_EN
      sync_now = sync;
`endif
      for (int c = 0; c < NUM_CH; c++) begin
         start = 0;
         if (m_run[c] && sync_now && en[c]) start = 1;
         else if (m_run[c]) begin
            m_pos[c]++;
            if (m_pos[c] == m_h[c] + m_l[c]) begin
               if (en[c]) start = 1;
               else m_run[c] = 0;
            end
         end else start = en[c];
         if (start) begin
            if (m_pend[c]) begin
               m_h[c] = eff(m_sh[c]); m_l[c] = eff(m_sl[c]); m_pend[c] = 0;
            end
            m_run[c] = 1; m_pos[c] = 0;
         end
         e.c[c] = m_run[c] && (m_pos[c] < m_h[c]);
         e.r[c] = start;
         e.b[c] = m_run[c];
         if (cfg_we && int'(cfg_ch) == c) begin
            m_sh[c] = int'(cfg_high); m_sl[c] = int'(cfg_low); m_pend[c] = 1;
         end
         e.p[c] = m_pend[c];
      end
      q.push_back(e);
   endtask

   task automatic step();
      obs_t a, e;
      model_step();
      @(posedge clock);
      #1;
      a = {clk_out, rise, busy, pend};
      total++;
      if (q.size() == 0) begin
         bad++;
         $display("FAIL scoreboard: queue empty, got %h", a);
      end else begin
         e = q.pop_front();
         if (a !== e) begin
            bad++;
            $display("FAIL cycle t=%0t clk/rise/busy/pend got %b_%b_%b_%b want %b_%b_%b_%b",
                     $time, a.c, a.r, a.b, a.p, e.c, e.r, e.b, e.p);
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic write_cfg(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] hi,
                            input logic [CNT_W-1:0] lo);
      cfg_we = 1'b1; cfg_ch = ch; cfg_high = hi; cfg_low = lo;
   endtask

   phase_t tbl[10];
   int hc, rc;

   initial begin
      tbl[0] = '{4'b0001, 1'b0, 3'd0, 8'd0, 8'd0, 20, 4'b0001, 4'b0000};
      tbl[1] = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 5,  4'b0011, 4'b0000};
      tbl[2] = '{4'b0011, 1'b1, 3'd1, 8'd3, 8'd1, 1,  4'b0011, 4'b0010};
      tbl[3] = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 30, 4'b0011, 4'b0000};
      tbl[4] = '{4'b0011, 1'b1, 3'd2, 8'd0, 8'd0, 1,  4'b0011, 4'b0100};
      tbl[5] = '{4'b0111, 1'b0, 3'd0, 8'd0, 8'd0, 10, 4'b0111, 4'b0000};
      tbl[6] = '{4'b0111, 1'b1, 3'd5, 8'd1, 8'd1, 1,  4'b0111, 4'b0000};
      tbl[7] = '{4'b0111, 1'b1, 3'd7, 8'd2, 8'd2, 1,  4'b0111, 4'b0000};
      tbl[8] = '{4'b0110, 1'b0, 3'd0, 8'd0, 8'd0, 30, 4'b0110, 4'b0000};
      tbl[9] = '{4'b0000, 1'b0, 3'd0, 8'd0, 8'd0, 30, 4'b0000, 4'b0000};

      repeat (2) @(posedge clock);
      #1;
      check("rst_clk", 32'(clk_out), 0);
      check("rst_rise", 32'(rise), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_pend", 32'(pend), 0);
      @(negedge clock);
      reset = 1'b1;
      model_reset();

      // Default 9/9 on channel 0: one-cycle start latency, 9 high, period 18.
      en = 4'b0001;
      step();
      check("first_rise0", 32'(rise[0]), 1);
      check("first_clk0", 32'(clk_out[0]), 1);
      hc = 1; rc = 0;
      for (int k = 0; k < 17; k++) begin
         step();
         hc += int'(clk_out[0]);
         rc += int'(rise[0]);
      end
      check("high_len0", 32'(hc), 9);
      check("no_extra_rise0", 32'(rc), 0);
      step();
      check("period18_rise0", 32'(rise[0]), 1);

      for (int p = 0; p < 10; p++) begin
         en = tbl[p].en;
         cfg_we = tbl[p].we; cfg_ch = tbl[p].ch; cfg_high = tbl[p].hi; cfg_low = tbl[p].lo;
         for (int k = 0; k < tbl[p].n; k++) step();
         cfg_we = 1'b0;
         check($sformatf("phase%0d_busy", p), 32'(busy), 32'(tbl[p].exp_busy));
         check($sformatf("phase%0d_pend", p), 32'(pend), 32'(tbl[p].exp_pend));
      end

      // Async reset mid-run clears everything without waiting for an edge.
      write_cfg(3'd1, 8'd2, 8'd2);
      en = 4'b1111;
      repeat (3) step();
      cfg_we = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("async_rst_clk", 32'(clk_out), 0);
      check("async_rst_busy", 32'(busy), 0);
      check("async_rst_pend", 32'(pend), 0);
      en = '0;
      @(negedge clock);
      reset = 1'b1;
      model_reset();

      // Drop en[0] in the third high cycle: the period still completes.
      en = 4'b0001;
      repeat (3) step();
      en = 4'b0000;
      hc = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         hc += int'(clk_out[0]);
      end
      check("drop_rest_high", 32'(hc), 6);
      check("drop_busy_last_low", 32'(busy[0]), 1);
      step();
      check("drop_off_busy", 32'(busy[0]), 0);
      check("drop_off_clk", 32'(clk_out[0]), 0);
      check("drop_off_rise", 32'(rise[0]), 0);
      repeat (3) step();

      // Write landing on the reload edge of channel 3.
      en = 4'b1000;
      step();
      write_cfg(3'd3, 8'd4, 8'd4);
      step();
      cfg_we = 1'b0;
      repeat (16) step();
      write_cfg(3'd3, 8'd2, 8'd2);
      step();
      cfg_we = 1'b0;
      check("coinc_rise3", 32'(rise[3]), 1);
      check("coinc_pend3", 32'(pend[3]), 1);
      hc = int'(clk_out[3]);
      for (int k = 0; k < 7; k++) begin
         step();
         hc += int'(clk_out[3]);
      end
      check("coinc_old_shadow_high", 32'(hc), 4);
      step();
      check("coinc_next_rise3", 32'(rise[3]), 1);
      check("coinc_next_pend3", 32'(pend[3]), 0);
      repeat (8) step();

`ifdef CLKDIV_SYNC_EN
      write_cfg(3'd0, 8'd5, 8'd5);
      step();
      write_cfg(3'd1, 8'd2, 8'd7);
      step();
      cfg_we = 1'b0;
      en = 4'b1011;
      repeat (13) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      check("sync_rise01", 32'(rise[1:0]), 3);
      check("sync_ch2_low", 32'(clk_out[2]), 0);
      repeat (12) step();
`endif

      en = '0;
      repeat (20) step();
      check("final_idle", 32'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
